// File: rtl/time_mux_capture.sv
// time_mux_capture: rebuilds four frame-coherent seven-segment digits from a scanned an/sseg bus.
// Ports:
//   clk, reset(async, active-low)
//   an[3:0]    scanned anodes, active-low one-hot
//   sseg[6:0]  scanned segments, active-low {g,f,e,d,c,b,a}
//   out0..out3 last complete frame's per-digit patterns
//   hex, hex_ok  decoded nibbles {hex3..hex0} and per-digit glyph legality
//   frame_done pulse on frame update, frame_valid sticky, scan_err pulse
module time_mux_capture #(
    parameter int STABLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  sseg,
    output logic [6:0]  out0,
    output logic [6:0]  out1,
    output logic [6:0]  out2,
    output logic [6:0]  out3,
    output logic [15:0] hex,
    output logic [3:0]  hex_ok,
    output logic        frame_done,
    output logic        frame_valid,
    output logic        scan_err
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    typedef enum logic [1:0] {SYNC, EXP1, EXP2, EXP3} state_t;
    state_t        state;
    logic [3:0]    an_s1, an_s2;
    logic [6:0]    sseg_s1, sseg_s2;
    logic [CW-1:0] cnt, cnt_n;
    logic [6:0]    sh0, sh1, sh2;
    logic          chg, cap, one_cold;
    logic [1:0]    k;

    // an_s2/sseg_s2 hold the previous registered sample, so the count is
    // evaluated combinationally and a stable sample is captured on the edge
    // where it has been seen STABLE_CYCLES times.
    assign chg      = {an_s1, sseg_s1} != {an_s2, sseg_s2};
    assign cnt_n    = chg ? CW'(1) : (cnt == CW'(STABLE_CYCLES) ? cnt : cnt + CW'(1));
    assign cap      = cnt_n == CW'(STABLE_CYCLES) && (chg || cnt != CW'(STABLE_CYCLES));
    assign one_cold = an_s1 == 4'b1110 || an_s1 == 4'b1101 || an_s1 == 4'b1011 || an_s1 == 4'b0111;
    assign k        = !an_s1[0] ? 2'd0 : !an_s1[1] ? 2'd1 : !an_s1[2] ? 2'd2 : 2'd3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_s1       <= 4'hF;
            an_s2       <= 4'hF;
            sseg_s1     <= 7'h7F;
            sseg_s2     <= 7'h7F;
            cnt         <= '0;
            state       <= SYNC;
            sh0         <= 7'h7F;
            sh1         <= 7'h7F;
            sh2         <= 7'h7F;
            out0        <= 7'h7F;
            out1        <= 7'h7F;
            out2        <= 7'h7F;
            out3        <= 7'h7F;
            frame_done  <= 1'b0;
            frame_valid <= 1'b0;
            scan_err    <= 1'b0;
        end else begin
            an_s1      <= an;
            sseg_s1    <= sseg;
            an_s2      <= an_s1;
            sseg_s2    <= sseg_s1;
            cnt        <= cnt_n;
            frame_done <= 1'b0;
            scan_err   <= 1'b0;
            if (cap && an_s1 != 4'hF) begin
                if (!one_cold) begin
                    scan_err <= 1'b1;
                    state    <= SYNC;
                end else if (state == SYNC) begin
                    // mid-frame entry: wait silently for digit 0
                    if (k == 2'd0) begin
                        sh0   <= sseg_s1;
                        state <= EXP1;
                    end
                end else if (state_t'(k) == state) begin
                    if (k == 2'd1) sh1 <= sseg_s1;
                    if (k == 2'd2) sh2 <= sseg_s1;
                    state <= k == 2'd3 ? SYNC : state_t'(k + 2'd1);
                    if (k == 2'd3) begin
                        out0        <= sh0;
                        out1        <= sh1;
                        out2        <= sh2;
                        out3        <= sseg_s1;
                        frame_done  <= 1'b1;
                        frame_valid <= 1'b1;
                    end
                end else begin
                    scan_err <= 1'b1;
                    if (k == 2'd0) begin
                        sh0   <= sseg_s1;
                        state <= EXP1;
                    end else begin
                        state <= SYNC;
                    end
                end
            end
        end
    end

    // returns {legal, nibble}; illegal patterns decode to 0
    function automatic logic [4:0] dec(input logic [6:0] p);
        case (p)
            7'b1000000: dec = 5'h10;
            7'b1111001: dec = 5'h11;
            7'b0100100: dec = 5'h12;
            7'b0110000: dec = 5'h13;
            7'b0011001: dec = 5'h14;
            7'b0010010: dec = 5'h15;
            7'b0000010: dec = 5'h16;
            7'b1111000: dec = 5'h17;
            7'b0000000: dec = 5'h18;
            7'b0010000: dec = 5'h19;
            7'b0001000: dec = 5'h1A;
            7'b0000011: dec = 5'h1B;
            7'b1000110: dec = 5'h1C;
            7'b0100001: dec = 5'h1D;
            7'b0000110: dec = 5'h1E;
            7'b0001110: dec = 5'h1F;
            default:    dec = 5'h00;
        endcase
    endfunction

    assign {hex_ok[0], hex[3:0]}   = dec(out0);
    assign {hex_ok[1], hex[7:4]}   = dec(out1);
    assign {hex_ok[2], hex[11:8]}  = dec(out2);
    assign {hex_ok[3], hex[15:12]} = dec(out3);
endmodule

// File: tb/tb_time_mux_capture.sv
// tb_time_mux_capture: table, directed and randomized checks of time_mux_capture.
module tb_time_mux_capture;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  an = 4'hF;
    logic [6:0]  sseg = 7'h7F;
    logic [6:0]  a_o0, a_o1, a_o2, a_o3, b_o0, b_o1, b_o2, b_o3;
    logic [15:0] a_hex, b_hex;
    logic [3:0]  a_ok, b_ok;
    logic        a_fd, a_fv, a_err, b_fd, b_fv, b_err;
    int          errors = 0;
    int          checks = 0;

    logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    time_mux_capture #(.STABLE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .an(an), .sseg(sseg),
        .out0(a_o0), .out1(a_o1), .out2(a_o2), .out3(a_o3),
        .hex(a_hex), .hex_ok(a_ok), .frame_done(a_fd), .frame_valid(a_fv), .scan_err(a_err));

    time_mux_capture #(.STABLE_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .an(an), .sseg(sseg),
        .out0(b_o0), .out1(b_o1), .out2(b_o2), .out3(b_o3),
        .hex(b_hex), .hex_ok(b_ok), .frame_done(b_fd), .frame_valid(b_fv), .scan_err(b_err));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  s;
        logic        fd;
        logic        err;
        logic [15:0] hex;
        logic [3:0]  ok;
    } vec_t;
    vec_t tv[$];

    // behavioural model: digits collected in order into a queue
    logic [6:0]  m_q[$];
    logic [6:0]  m_out [4];
    logic        m_fd, m_err, m_valid;
    logic [10:0] m_prev;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick(input logic [3:0] a, input logic [6:0] s);
        an = a;
        sseg = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        an = 4'hF;
        sseg = 7'h7F;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic add(input logic [3:0] a, input logic [6:0] s, input logic fd, input logic err,
                       input logic [15:0] h, input logic [3:0] ok);
        vec_t v;
        v.an = a; v.s = s; v.fd = fd; v.err = err; v.hex = h; v.ok = ok;
        tv.push_back(v);
    endtask

    function automatic logic [4:0] exp_dec(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (glyph[i] == p) return {1'b1, 4'(i)};
        return 5'h00;
    endfunction

    task automatic model_reset;
        m_q.delete();
        for (int i = 0; i < 4; i++) m_out[i] = 7'h7F;
        m_fd = 0; m_err = 0; m_valid = 0;
        m_prev = {4'hF, 7'h7F};
    endtask

    task automatic model_step(input logic [3:0] a, input logic [6:0] s);
        int k;
        m_fd = 0;
        m_err = 0;
        if ({a, s} != m_prev && a != 4'hF) begin
            if ($countones(~a) != 1) begin
                m_err = 1;
                m_q.delete();
            end else begin
                k = 0;
                for (int i = 0; i < 4; i++) if (!a[i]) k = i;
                if (m_q.size() == 0) begin
                    if (k == 0) m_q.push_back(s);
                end else if (k == m_q.size()) begin
                    m_q.push_back(s);
                    if (m_q.size() == 4) begin
                        for (int i = 0; i < 4; i++) m_out[i] = m_q[i];
                        m_fd = 1;
                        m_valid = 1;
                        m_q.delete();
                    end
                end else begin
                    m_err = 1;
                    m_q.delete();
                    if (k == 0) m_q.push_back(s);
                end
            end
        end
        m_prev = {a, s};
    endtask

    task automatic model_check;
        logic [15:0] eh;
        logic [3:0]  eo;
        for (int i = 0; i < 4; i++) {eo[i], eh[i*4 +: 4]} = exp_dec(m_out[i]);
        chk("rnd_out", {a_o3, a_o2, a_o1, a_o0}, {m_out[3], m_out[2], m_out[1], m_out[0]});
        chk("rnd_hex", a_hex, eh);
        chk("rnd_ok", a_ok, eo);
        chk("rnd_fd", a_fd, m_fd);
        chk("rnd_err", a_err, m_err);
        chk("rnd_valid", a_fv, m_valid);
    endtask

    initial begin
        logic [3:0] ra;
        logic [6:0] rs;
        int d, seen;

        do_reset;
        chk("rst_out", {a_o3, a_o2, a_o1, a_o0}, {4{7'h7F}});
        chk("rst_hex", {a_hex, a_ok}, 20'h0);
        chk("rst_flags", {a_fd, a_fv, a_err, b_fd, b_fv, b_err}, 6'b0);

        // in-order frame
        add(4'b1110, glyph[0], 0, 0, 16'h0, 4'h0);
        add(4'b1101, glyph[1], 0, 0, 16'h0, 4'h0);
        add(4'b1011, glyph[2], 0, 0, 16'h0, 4'h0);
        add(4'b0111, glyph[3], 0, 0, 16'h0, 4'h0);
        add(4'b1111, 7'h7F,    1, 0, 16'h3210, 4'hF);
        // scan entering at digit 2
        add(4'b1011, glyph[2], 0, 0, 16'h3210, 4'hF);
        add(4'b0111, glyph[3], 0, 0, 16'h3210, 4'hF);
        add(4'b1110, glyph[0], 0, 0, 16'h3210, 4'hF);
        add(4'b1101, glyph[1], 0, 0, 16'h3210, 4'hF);
        add(4'b1011, glyph[2], 0, 0, 16'h3210, 4'hF);
        add(4'b0111, glyph[3], 0, 0, 16'h3210, 4'hF);
        add(4'b1111, 7'h7F,    1, 0, 16'h3210, 4'hF);
        // skipped digit 2
        add(4'b1110, glyph[9], 0, 0, 16'h3210, 4'hF);
        add(4'b1101, glyph[8], 0, 0, 16'h3210, 4'hF);
        add(4'b0111, glyph[7], 0, 0, 16'h3210, 4'hF);
        add(4'b1111, 7'h7F,    0, 1, 16'h3210, 4'hF);
        add(4'b1111, 7'h7F,    0, 0, 16'h3210, 4'hF);
        // illegal anode, then a frame with blank dwells between digits
        add(4'b1110, glyph[0], 0, 0, 16'h3210, 4'hF);
        add(4'b1101, glyph[1], 0, 0, 16'h3210, 4'hF);
        add(4'b1100, glyph[2], 0, 0, 16'h3210, 4'hF);
        add(4'b1111, 7'h7F,    0, 1, 16'h3210, 4'hF);
        add(4'b1110, glyph[4], 0, 0, 16'h3210, 4'hF);
        add(4'b1111, 7'h7F,    0, 0, 16'h3210, 4'hF);
        add(4'b1101, glyph[5], 0, 0, 16'h3210, 4'hF);
        add(4'b1111, 7'h7F,    0, 0, 16'h3210, 4'hF);
        add(4'b1011, glyph[6], 0, 0, 16'h3210, 4'hF);
        add(4'b1111, 7'h7F,    0, 0, 16'h3210, 4'hF);
        add(4'b0111, glyph[7], 0, 0, 16'h3210, 4'hF);
        add(4'b1111, 7'h7F,    1, 0, 16'h7654, 4'hF);
        for (int i = 0; i < tv.size(); i++) begin
            tick(tv[i].an, tv[i].s);
            chk($sformatf("vec%0d_fd", i), a_fd, tv[i].fd);
            chk($sformatf("vec%0d_err", i), a_err, tv[i].err);
            chk($sformatf("vec%0d_hex", i), a_hex, tv[i].hex);
            chk($sformatf("vec%0d_ok", i), a_ok, tv[i].ok);
        end
        chk("tbl_out", {a_o3, a_o2, a_o1, a_o0}, {glyph[7], glyph[6], glyph[5], glyph[4]});
        chk("tbl_valid", a_fv, 1'b1);

        // STABLE_CYCLES=3: 2-clk dwells never capture, 3-clk dwells do
        do_reset;
        seen = 0;
        for (int j = 0; j < 4; j++)
            repeat (2) begin
                tick(~(4'b0001 << j), glyph[10 + j]);
                seen += int'(b_fd);
            end
        repeat (4) begin
            tick(4'hF, 7'h7F);
            seen += int'(b_fd);
        end
        for (int j = 0; j < 4; j++)
            repeat (3) begin
                tick(~(4'b0001 << j), glyph[10 + j]);
                seen += int'(b_fd);
            end
        chk("s3_no_early_fd", seen, 0);
        tick(4'hF, 7'h7F);
        chk("s3_fd", b_fd, 1'b1);
        chk("s3_hex", b_hex, 16'hDCBA);
        chk("s3_ok", b_ok, 4'hF);

        // blank digit 1, then async reset mid-frame
        do_reset;
        tick(4'b1110, glyph[0]);
        tick(4'b1101, 7'h7F);
        tick(4'b1011, glyph[2]);
        tick(4'b0111, glyph[3]);
        tick(4'b1111, 7'h7F);
        chk("blank_fd", a_fd, 1'b1);
        chk("blank_out1", a_o1, 7'h7F);
        chk("blank_ok", a_ok, 4'b1101);
        chk("blank_hex", a_hex, 16'h3200);
        tick(4'b1110, glyph[5]);
        tick(4'b1101, glyph[6]);
        #2;
        reset = 1'b0;
        #1;
        chk("async_out", {a_o3, a_o2, a_o1, a_o0}, {4{7'h7F}});
        chk("async_hex", {a_hex, a_ok}, 20'h0);
        chk("async_flags", {a_fd, a_fv, a_err}, 3'b0);

        // randomized scans against the model
        do_reset;
        model_reset;
        d = 0;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                7:       ra = 4'hF;
                8:       ra = 4'($urandom);
                9:       ra = ~(4'b0001 << $urandom_range(0, 3));
                default: begin
                    ra = ~(4'b0001 << d);
                    d = (d + 1) % 4;
                end
            endcase
            rs = $urandom_range(0, 4) != 0 ? glyph[$urandom_range(0, 15)] : 7'($urandom);
            repeat ($urandom_range(1, 2)) begin
                tick(ra, rs);
                model_check;
                model_step(ra, rs);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
